reg_wr_arbiter: RTL and testbench
=================================

Name: reg_wr_arbiter

Overview:
- Shares the single regfile write port between two requesters: the control FSM's SPI configuration byte writes (A) and the measure block's 96-bit result writes (B).
- Buffers one request per requester and holds any write off while a register read is in progress.
- Applies fixed A-over-B priority, with a starvation guard for B.
- Sits between control/measure and regfile; replaces the ad-hoc OR/mux on the regfile write inputs.

Parameters:
- A_DATA_W, 8, width of requester A data.
- B_DATA_W, 96, width of requester B data and of the regfile write data.
- A_ADDR_W, 2, width of requester A address.
- STARVE_MAX, 4, consecutive A commits allowed while B pending before B is forced.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active high
- rd_busy_i  in  1  register read in progress; no write may commit
- a_wr_en_i  in  1  A write pulse
- a_wr_addr_i  in  A_ADDR_W  A register address
- a_wr_data_i  in  A_DATA_W  A data
- b_wr_en_i  in  1  B write pulse
- b_wr_data_i  in  B_DATA_W  B result data
- reg_wr_en_o  out  1  regfile write strobe
- reg_wr_addr_o  out  A_ADDR_W+1  regfile address; MSB selects result bank
- reg_wr_data_o  out  B_DATA_W  regfile write data
- a_pend_o  out  1  A buffer valid
- b_pend_o  out  1  B buffer valid
- a_drop_o  out  1  one-cycle pulse: A request discarded
- b_drop_o  out  1  one-cycle pulse: B buffer overwritten

Behaviour:
- Reset (rst_i high at an edge):
  - State IDLE; both buffers invalid; starvation count 0.
  - All outputs 0 the next cycle, including when reset hits mid-write.
  - Pending requests are lost.
- Capture:
  - a_wr_en_i/b_wr_en_i high at an edge loads the respective buffer; pend is set the next cycle.
- A overflow (A buffer valid, not committing this cycle, a_wr_en_i high):
  - New request is discarded.
  - a_drop_o pulses the next cycle.
  - Buffer is unchanged.
- B overflow (B buffer valid, not committing this cycle, b_wr_en_i high):
  - Buffer is overwritten with the newest result.
  - b_drop_o pulses the next cycle.
  - If the buffer is held in WR_B, the later commit writes the newest data.
- Commit cycle with a new pulse from the same requester:
  - Commit uses the old data.
  - New data is captured and pend stays 1.
  - No drop.
- FSM states: IDLE, WR_A, WR_B.
  - IDLE -> WR_A if A pending and not (B pending and count == STARVE_MAX).
  - IDLE -> WR_B if B pending and (A not pending or count == STARVE_MAX).
  - Otherwise stay in IDLE.
  - rd_busy_i does not block the IDLE decision.
  - WR_x -> IDLE when rd_busy_i == 0 (commit); hold WR_x while rd_busy_i == 1.
  - An IDLE cycle always separates commits.
- reg_wr_en_o = (state == WR_A or WR_B) & ~rd_busy_i. This is combinational, the only combinational output path. Commit = reg_wr_en_o.
- Address and data:
  - WR_A: reg_wr_addr_o = {0, A addr}; reg_wr_data_o = A data zero-extended to B_DATA_W.
  - WR_B: reg_wr_addr_o = {1, 0...0}; reg_wr_data_o = B data.
  - IDLE: both outputs 0.
- Buffer clear: on commit, the buffer is cleared at that edge unless a same-cycle pulse reloads it.
- Starvation counter:
  - Increments on an A commit while B is pending; saturates at STARVE_MAX.
  - Clears on a B commit or when B is not pending.
- Latency with rd_busy_i low:
  - Pulse at cycle 0 -> pend at 1 -> WR state at 2 -> reg_wr_en_o at 2 -> pend cleared at 3.
  - Throughput: one commit per 2 cycles.

Test Plan:
1. A pulse, addr=2, data=8'h5A, rd_busy_i=0 -> reg_wr_en_o high only in cycle 2, addr=3'b010, data=96'h5A; a_pend_o low from cycle 3.
2. B pulse, data=96'h0123_4567_89AB_CDEF_0011_2233, rd_busy_i=1 for cycles 1-6 -> reg_wr_en_o low through cycle 6; single strobe in cycle 7 with addr=3'b100 and that data.
3. A (addr=1, 8'hC3) and B pulses in the same cycle -> A commits in cycle 2, B in cycle 4, no drops.
4. STARVE_MAX=4, B pending, A pulsed every 2 cycles keeping A always pending -> four A commits, then B commits, then A resumes.
5. rd_busy_i=1; A pulses 8'h11 then 8'h22 -> a_drop_o pulses once, 8'h11 committed. B pulses X then Y -> b_drop_o pulses once, Y committed.
6. rst_i asserted for 1 cycle while in WR_B with rd_busy_i=1 -> next cycle all outputs 0; after rd_busy_i drops, no write ever occurs.

Source files
------------

// File: rtl/reg_wr_arbiter.sv
// Regfile write-port arbiter: one-deep buffers for the SPI config writer (A) and
// the measurement result writer (B), fixed A priority with a B starvation guard.
module reg_wr_arbiter #(
    parameter int A_DATA_W   = 8,
    parameter int B_DATA_W   = 96,
    parameter int A_ADDR_W   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rd_busy_i,
    input  logic                a_wr_en_i,
    input  logic [A_ADDR_W-1:0] a_wr_addr_i,
    input  logic [A_DATA_W-1:0] a_wr_data_i,
    input  logic                b_wr_en_i,
    input  logic [B_DATA_W-1:0] b_wr_data_i,
    output logic                reg_wr_en_o,
    output logic [A_ADDR_W:0]   reg_wr_addr_o,
    output logic [B_DATA_W-1:0] reg_wr_data_o,
    output logic                a_pend_o,
    output logic                b_pend_o,
    output logic                a_drop_o,
    output logic                b_drop_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  aValid_q, aValid_d;
    logic [A_ADDR_W-1:0]   aAddr_q, aAddr_d;
    logic [A_DATA_W-1:0]   aData_q, aData_d;
    logic                  bValid_q, bValid_d;
    logic [B_DATA_W-1:0]   bData_q, bData_d;
    logic                  aDrop_q, aDrop_d;
    logic                  bDrop_q, bDrop_d;
    logic [CNT_W-1:0]      starveCnt_q, starveCnt_d;

    logic                  aCommit;
    logic                  bCommit;
    logic                  starveHit;

    assign aCommit   = (state_q == WR_A) && !rd_busy_i;
    assign bCommit   = (state_q == WR_B) && !rd_busy_i;
    assign starveHit = bValid_q && (starveCnt_q == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            aValid_q    <= 1'b0;
            aAddr_q     <= '0;
            aData_q     <= '0;
            bValid_q    <= 1'b0;
            bData_q     <= '0;
            aDrop_q     <= 1'b0;
            bDrop_q     <= 1'b0;
            starveCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            aValid_q    <= aValid_d;
            aAddr_q     <= aAddr_d;
            aData_q     <= aData_d;
            bValid_q    <= bValid_d;
            bData_q     <= bData_d;
            aDrop_q     <= aDrop_d;
            bDrop_q     <= bDrop_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    // The IDLE decision ignores rd_busy_i; the WR states simply wait it out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aValid_q && !starveHit) begin
                    state_d = WR_A;
                end else if (bValid_q) begin
                    state_d = WR_B;
                end
            end
            WR_A: begin
                if (!rd_busy_i) begin
                    state_d = IDLE;
                end
            end
            WR_B: begin
                if (!rd_busy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A keeps its oldest request; a commit frees the slot in time for a same-cycle pulse.
    always_comb begin
        aValid_d = aValid_q;
        aAddr_d  = aAddr_q;
        aData_d  = aData_q;
        aDrop_d  = 1'b0;
        if (a_wr_en_i) begin
            if (!aValid_q || aCommit) begin
                aValid_d = 1'b1;
                aAddr_d  = a_wr_addr_i;
                aData_d  = a_wr_data_i;
            end else begin
                aDrop_d = 1'b1;
            end
        end else if (aCommit) begin
            aValid_d = 1'b0;
        end
    end

    // B always keeps the newest result, even while it is being held in WR_B.
    always_comb begin
        bValid_d = bValid_q;
        bData_d  = bData_q;
        bDrop_d  = 1'b0;
        if (b_wr_en_i) begin
            bValid_d = 1'b1;
            bData_d  = b_wr_data_i;
            bDrop_d  = bValid_q && !bCommit;
        end else if (bCommit) begin
            bValid_d = 1'b0;
        end
    end

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (bCommit || !bValid_q) begin
            starveCnt_d = '0;
        end else if (aCommit && (starveCnt_q != CNT_W'(STARVE_MAX))) begin
            starveCnt_d = starveCnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        reg_wr_en_o   = ((state_q == WR_A) || (state_q == WR_B)) && !rd_busy_i;
        reg_wr_addr_o = '0;
        reg_wr_data_o = '0;
        case (state_q)
            WR_A: begin
                reg_wr_addr_o = {1'b0, aAddr_q};
                reg_wr_data_o = B_DATA_W'(aData_q);
            end
            WR_B: begin
                reg_wr_addr_o = {1'b1, {A_ADDR_W{1'b0}}};
                reg_wr_data_o = bData_q;
            end
            default: begin
                reg_wr_addr_o = '0;
                reg_wr_data_o = '0;
            end
        endcase
    end

    assign a_pend_o = aValid_q;
    assign b_pend_o = bValid_q;
    assign a_drop_o = aDrop_q;
    assign b_drop_o = bDrop_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: expected writes (with their commit cycle)
// are queued as stimulus is driven and retired by a monitor on every write strobe.
module tb_reg_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rd_busy_i;
    logic        a_wr_en_i;
    logic [1:0]  a_wr_addr_i;
    logic [7:0]  a_wr_data_i;
    logic        b_wr_en_i;
    logic [95:0] b_wr_data_i;
    logic        reg_wr_en_o;
    logic [2:0]  reg_wr_addr_o;
    logic [95:0] reg_wr_data_o;
    logic        a_pend_o;
    logic        b_pend_o;
    logic        a_drop_o;
    logic        b_drop_o;

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [95:0] data;
    } wr_t;

    wr_t expQ[$];
    int  cyc       = 0;
    int  checks    = 0;
    int  passes    = 0;
    int  aDropCnt  = 0;
    int  bDropCnt  = 0;
    int  wrCnt     = 0;

    reg_wr_arbiter #(
        .A_DATA_W(8), .B_DATA_W(96), .A_ADDR_W(2), .STARVE_MAX(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rd_busy_i(rd_busy_i),
        .a_wr_en_i(a_wr_en_i), .a_wr_addr_i(a_wr_addr_i), .a_wr_data_i(a_wr_data_i),
        .b_wr_en_i(b_wr_en_i), .b_wr_data_i(b_wr_data_i),
        .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o),
        .reg_wr_data_o(reg_wr_data_o), .a_pend_o(a_pend_o), .b_pend_o(b_pend_o),
        .a_drop_o(a_drop_o), .b_drop_o(b_drop_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One cycle of stimulus: inputs live from just after one edge to just after the next.
    task automatic applyStimulus(input logic aEn, input logic [1:0] aAddr, input logic [7:0] aData,
                                 input logic bEn, input logic [95:0] bData, input logic busy);
        a_wr_en_i   = aEn;
        a_wr_addr_i = aAddr;
        a_wr_data_i = aData;
        b_wr_en_i   = bEn;
        b_wr_data_i = bData;
        rd_busy_i   = busy;
        @(posedge clk_i);
        #1;
        a_wr_en_i = 1'b0;
        b_wr_en_i = 1'b0;
    endtask

    task automatic idleCycles(input int n, input logic busy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 96'h0, busy);
        end
    endtask

    task automatic expectWrite(input int c, input logic [2:0] addr, input logic [95:0] data);
        wr_t w;
        w.cyc  = c;
        w.addr = addr;
        w.data = data;
        expQ.push_back(w);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while (expQ.size() != 0 && budget < 30) begin
            idleCycles(1, 1'b0);
            budget++;
        end
        checkOutput(tag, 128'(expQ.size()), 128'd0);
    endtask

    // Every strobe must match the head of the scoreboard, including its cycle.
    always @(negedge clk_i) begin
        if (a_drop_o === 1'b1) aDropCnt++;
        if (b_drop_o === 1'b1) bDropCnt++;
        if (reg_wr_en_o === 1'b1) begin
            wr_t w;
            wrCnt++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_wr_en", 128'(reg_wr_en_o), 128'd0);
            end else begin
                w = expQ.pop_front();
                checkOutput("wr_addr", 128'(reg_wr_addr_o), 128'(w.addr));
                checkOutput("wr_data", 128'(reg_wr_data_o), 128'(w.data));
                if (w.cyc >= 0) checkOutput("wr_cycle", 128'(cyc), 128'(w.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int c0;
        int c1;
        int aD;
        int bD;
        int w0;

        rst_i = 1'b1;
        rd_busy_i = 1'b0;
        a_wr_en_i = 1'b0;
        a_wr_addr_i = 2'd0;
        a_wr_data_i = 8'h00;
        b_wr_en_i = 1'b0;
        b_wr_data_i = 96'h0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        checkOutput("rst_wr_en", 128'(reg_wr_en_o), 128'd0);
        checkOutput("rst_addr", 128'(reg_wr_addr_o), 128'd0);
        checkOutput("rst_data", 128'(reg_wr_data_o), 128'd0);
        checkOutput("rst_pend", 128'({a_pend_o, b_pend_o}), 128'd0);
        checkOutput("rst_drop", 128'({a_drop_o, b_drop_o}), 128'd0);

        $display("[TB] test 1: single A write");
        c0 = cyc;
        expectWrite(c0 + 2, 3'b010, 96'h5A);
        applyStimulus(1'b1, 2'd2, 8'h5A, 1'b0, 96'h0, 1'b0);
        checkOutput("t1_apend_c1", 128'(a_pend_o), 128'd1);
        idleCycles(1, 1'b0);
        checkOutput("t1_apend_c2", 128'(a_pend_o), 128'd1);
        idleCycles(1, 1'b0);
        checkOutput("t1_apend_c3", 128'(a_pend_o), 128'd0);
        drain("t1_drain");

        $display("[TB] test 2: B write held by rd_busy");
        c0 = cyc;
        expectWrite(c0 + 7, 3'b100, 96'h0123_4567_89AB_CDEF_0011_2233);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 96'h0123_4567_89AB_CDEF_0011_2233, 1'b0);
        idleCycles(6, 1'b1);
        checkOutput("t2_bpend_held", 128'(b_pend_o), 128'd1);
        idleCycles(2, 1'b0);
        checkOutput("t2_bpend_clr", 128'(b_pend_o), 128'd0);
        drain("t2_drain");

        $display("[TB] test 3: simultaneous A and B");
        aD = aDropCnt; bD = bDropCnt;
        c0 = cyc;
        expectWrite(c0 + 2, 3'b001, 96'hC3);
        expectWrite(c0 + 4, 3'b100, 96'hFEED_0000_0000_0000_0000_BEEF);
        applyStimulus(1'b1, 2'd1, 8'hC3, 1'b1, 96'hFEED_0000_0000_0000_0000_BEEF, 1'b0);
        drain("t3_drain");
        checkOutput("t3_no_drops", 128'((aDropCnt - aD) + (bDropCnt - bD)), 128'd0);

        $display("[TB] test 4: starvation guard");
        aD = aDropCnt; bD = bDropCnt;
        c0 = cyc;
        expectWrite(c0 + 2,  3'b011, 96'h40);
        expectWrite(c0 + 4,  3'b011, 96'h41);
        expectWrite(c0 + 6,  3'b011, 96'h42);
        expectWrite(c0 + 8,  3'b011, 96'h43);
        expectWrite(c0 + 10, 3'b100, 96'hABCD);
        expectWrite(c0 + 12, 3'b011, 96'h44);
        applyStimulus(1'b1, 2'd3, 8'h40, 1'b1, 96'hABCD, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            idleCycles(1, 1'b0);
            applyStimulus(1'b1, 2'd3, 8'(8'h40 + k), 1'b0, 96'h0, 1'b0);
        end
        checkOutput("t4_bpend_starved", 128'(b_pend_o), 128'd1);
        drain("t4_drain");
        checkOutput("t4_no_drops", 128'((aDropCnt - aD) + (bDropCnt - bD)), 128'd0);

        $display("[TB] test 5: overflow while rd_busy");
        aD = aDropCnt; bD = bDropCnt;
        applyStimulus(1'b1, 2'd0, 8'h11, 1'b0, 96'h0, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'h22, 1'b0, 96'h0, 1'b1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 96'h0000_0000_0000_0000_0000_0AAA, 1'b1);
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 96'h0000_0000_0000_0000_0000_0BBB, 1'b1);
        idleCycles(2, 1'b1);
        checkOutput("t5_a_drop", 128'(aDropCnt - aD), 128'd1);
        checkOutput("t5_b_drop", 128'(bDropCnt - bD), 128'd1);
        c1 = cyc;
        expectWrite(c1,     3'b000, 96'h11);
        expectWrite(c1 + 2, 3'b100, 96'h0BBB);
        drain("t5_drain");
        checkOutput("t5_pend_clr", 128'({a_pend_o, b_pend_o}), 128'd0);

        $display("[TB] test 6: reset while holding WR_B");
        applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 96'h5555, 1'b1);
        applyStimulus(1'b1, 2'd2, 8'h77, 1'b0, 96'h0, 1'b1);
        idleCycles(1, 1'b1);
        checkOutput("t6_pend_before", 128'({a_pend_o, b_pend_o}), 128'd3);
        w0 = wrCnt;
        rst_i = 1'b1;
        idleCycles(1, 1'b1);
        rst_i = 1'b0;
        checkOutput("t6_wr_en", 128'(reg_wr_en_o), 128'd0);
        checkOutput("t6_addr", 128'(reg_wr_addr_o), 128'd0);
        checkOutput("t6_data", 128'(reg_wr_data_o), 128'd0);
        checkOutput("t6_pend", 128'({a_pend_o, b_pend_o}), 128'd0);
        checkOutput("t6_drop", 128'({a_drop_o, b_drop_o}), 128'd0);
        idleCycles(12, 1'b0);
        checkOutput("t6_no_write", 128'(wrCnt - w0), 128'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
